// File: rtl/pixel_plot_buffer.sv
// pixel_plot_buffer: range-checks plot requests against the screen, queues
// in-range pixels as {linear address, colour} and drains them into the
// framebuffer write port under memory backpressure.
module pixel_plot_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_plot,
  output logic        in_ready,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        idle,
  output logic [7:0]  drop_count,
  output logic [15:0] wr_count
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned ENT_W  = ADDR_W + COL_W;

  // Limits widened by one bit so a limit equal to the coordinate range still compares correctly
  localparam logic [8:0]        X_LIM     = 9'(WIDTH);
  localparam logic [7:0]        Y_LIM     = 8'(HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;

  logic              empty_c;
  logic              full_c;
  logic              in_range_c;
  logic              push_c;
  logic              drop_c;
  logic              pop_c;
  logic [ADDR_W-1:0] new_addr_c;
  logic [ENT_W-1:0]  head_c;

  // Handshake, range check, FIFO bookkeeping and counters
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    wr_cnt_d   = wr_cnt_q;

    empty_c    = (count_q == '0);
    full_c     = (count_q == CNT_FULL);
    in_range_c = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);
    push_c     = in_plot && !full_c && in_range_c;
    drop_c     = in_plot && !full_c && !in_range_c;
    pop_c      = !empty_c && fb_ready;
    new_addr_c = ADDR_W'(in_y) * ROW_PITCH + ADDR_W'(in_x);
    head_c     = mem_q[rd_ptr_q];

    if (push_c) begin
      mem_d[wr_ptr_q] = {new_addr_c, in_colour};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wr_cnt_d = wr_cnt_q + 16'd1;
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (drop_c && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      wr_cnt_q   <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Outputs depend only on registered state; address/data forced to 0 when idle
  assign in_ready   = !full_c;
  assign fb_we      = !empty_c;
  assign fb_addr    = fb_we ? head_c[ENT_W-1:COL_W] : '0;
  assign fb_data    = fb_we ? head_c[COL_W-1:0] : '0;
  assign idle       = empty_c;
  assign drop_count = drop_cnt_q;
  assign wr_count   = wr_cnt_q;

endmodule

// File: tb/tb_pixel_plot_buffer.sv
// Directed testbench for pixel_plot_buffer with hand-computed expectations.
module tb_pixel_plot_buffer;

  logic        clk;
  logic        rst;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_plot;
  logic        in_ready;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic        idle;
  logic [7:0]  drop_count;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } req_t;

  req_t        pend[$];
  logic [17:0] got[$];

  pixel_plot_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_plot    (in_plot),
    .in_ready   (in_ready),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .idle       (idle),
    .drop_count (drop_count),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got_v, exp_v);
    end
  endtask

  task automatic add_req(input int x, input int y, input int c);
    req_t r;
    r.x = 8'(x);
    r.y = 7'(y);
    r.c = 3'(c);
    pend.push_back(r);
  endtask

  // One clock: present pending request, log completed writes, retire accepted request
  task automatic tick();
    logic acc;
    if (pend.size() > 0) begin
      in_x      = pend[0].x;
      in_y      = pend[0].y;
      in_colour = pend[0].c;
      in_plot   = 1'b1;
    end else begin
      in_plot   = 1'b0;
    end
    #1;
    acc = in_plot && in_ready;
    if (fb_we && fb_ready) got.push_back({fb_addr, fb_data});
    @(posedge clk);
    #1;
    if (acc) void'(pend.pop_front());
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend.size() > 0 || !idle) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 32'(pend.size() == 0 && idle), 32'd1);
  endtask

  initial begin
    int corner_addr[4];
    corner_addr = '{0, 159, 19040, 19199};

    rst = 1'b1; fb_ready = 1'b0; in_plot = 1'b0;
    in_x = '0; in_y = '0; in_colour = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_data", 32'(fb_data), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_wr", 32'(wr_count), 32'd0);

    // single plot (5,3) -> 3*160+5 = 485
    fb_ready = 1'b1;
    add_req(5, 3, 6);
    tick();
    check("single_we", 32'(fb_we), 32'd1);
    check("single_addr", 32'(fb_addr), 32'd485);
    check("single_data", 32'(fb_data), 32'd6);
    tick();
    check("single_idle", 32'(idle), 32'd1);
    check("single_wr", 32'(wr_count), 32'd1);
    got.delete();

    // corners streamed back to back
    add_req(0, 0, 1); add_req(159, 0, 2); add_req(0, 119, 3); add_req(159, 119, 4);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("corner_ready", 32'(in_ready), 32'd1);
    end
    check("corner_all_accepted", 32'(pend.size()), 32'd0);
    tick();
    check("corner_one_per_cycle", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      check("corner_addr", 32'(got[i][17:3]), 32'(corner_addr[i]));
      check("corner_data", 32'(got[i][2:0]), 32'(i + 1));
    end
    check("corner_idle", 32'(idle), 32'd1);
    check("corner_wr", 32'(wr_count), 32'd5);
    got.delete();

    // backpressure: (10i, i) -> addr 170i, colour i+1
    fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) add_req(10 * i, i, i + 1);
    for (int i = 0; i < 6; i++) tick();
    check("bp_accepted4", 32'(pend.size()), 32'd2);
    check("bp_ready_low", 32'(in_ready), 32'd0);
    check("bp_we", 32'(fb_we), 32'd1);
    check("bp_head_addr", 32'(fb_addr), 32'd0);
    check("bp_head_data", 32'(fb_data), 32'd1);
    check("bp_no_write", 32'(wr_count), 32'd5);
    fb_ready = 1'b1;
    drain(30);
    check("bp_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      check("bp_addr", 32'(got[i][17:3]), 32'(170 * i));
      check("bp_data", 32'(got[i][2:0]), 32'(i + 1));
    end
    check("bp_wr", 32'(wr_count), 32'd11);
    got.delete();

    // out-of-range requests interleaved with (10,10) -> 1610
    add_req(160, 0, 1); add_req(10, 10, 5); add_req(0, 120, 2); add_req(255, 127, 3);
    drain(20);
    check("drop_count3", 32'(drop_count), 32'd3);
    check("drop_writes", 32'(got.size()), 32'd1);
    if (got.size() > 0) begin
      check("drop_addr", 32'(got[0][17:3]), 32'd1610);
      check("drop_data", 32'(got[0][2:0]), 32'd5);
    end
    got.delete();

    // saturation: 3 + 300 drops clamps at 255
    for (int i = 0; i < 250; i++) add_req(200, 0, 0);
    drain(400);
    check("drop_253", 32'(drop_count), 32'd253);
    for (int i = 0; i < 50; i++) add_req(0, 127, 0);
    drain(400);
    check("drop_sat", 32'(drop_count), 32'd255);
    check("drop_no_write", 32'(got.size()), 32'd0);

    // reset with queued pixels discards them
    fb_ready = 1'b0;
    add_req(1, 1, 1); add_req(2, 2, 2); add_req(3, 3, 3);
    for (int i = 0; i < 3; i++) tick();
    check("pre_rst_we", 32'(fb_we), 32'd1);
    check("pre_rst_idle", 32'(idle), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_we", 32'(fb_we), 32'd0);
    check("post_rst_addr", 32'(fb_addr), 32'd0);
    check("post_rst_idle", 32'(idle), 32'd1);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_drop", 32'(drop_count), 32'd0);
    check("post_rst_wr", 32'(wr_count), 32'd0);
    fb_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_no_write", 32'(got.size()), 32'd0);
    check("post_rst_wr_final", 32'(wr_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
